// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the IF stage and the D-stage controller:
//   next-PC select encodings, the default reset PC / ROM base, the ROM depth
//   default, the nop encoding, and the branch-offset helper.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      NPC_SEL_SEQ    = 2'd0,
      NPC_SEL_BRANCH = 2'd1,
      NPC_SEL_JUMP   = 2'd2,
      NPC_SEL_JREG   = 2'd3
   } npc_sel_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
   localparam int unsigned IM_WORDS_DEFAULT = 1024;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

   // Sign-extended word offset of a conditional branch, in bytes.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// ----------------------------------------------------------------------------
// fetch_unit_npc_calc
//   Purely combinational next-PC selection for the IF stage, plus the
//   sequential PC+4 / PC+8 adders that are also exported to the IF/ID register.
// Ports
//   i_npc_sel        D-stage redirect request (npc_sel_e encoding)
//   i_br_cond        D-stage comparator result, qualifies BRANCH
//   i_pc_f           current fetch PC
//   i_pc4_d          PC+4 of the instruction in D
//   i_imm16_d        branch offset field of the instruction in D
//   i_instr_index_d  j/jal target field of the instruction in D
//   i_rs_val_d       forwarded rs value for jr/jalr
//   o_pc4_f          i_pc_f + 4
//   o_pc8_f          i_pc_f + 8
//   o_npc            PC to load on the next unstalled edge
// ----------------------------------------------------------------------------
module fetch_unit_npc_calc
   import fetch_unit_pkg::*;
(
   input  logic [1:0]  i_npc_sel,
   input  logic        i_br_cond,
   input  logic [31:0] i_pc_f,
   input  logic [31:0] i_pc4_d,
   input  logic [15:0] i_imm16_d,
   input  logic [25:0] i_instr_index_d,
   input  logic [31:0] i_rs_val_d,
   output logic [31:0] o_pc4_f,
   output logic [31:0] o_pc8_f,
   output logic [31:0] o_npc
);

   logic [31:0] w_pc4_f;
   logic [31:0] w_branch_target;
   logic [31:0] w_jump_target;

   // All adds are 32-bit and wrap silently; the fault flag in the top
   // catches any PC that leaves the ROM window.
   assign w_pc4_f         = i_pc_f + 32'd4;
   assign o_pc4_f         = w_pc4_f;
   assign o_pc8_f         = i_pc_f + 32'd8;
   assign w_branch_target = i_pc4_d + branch_offset(i_imm16_d);
   assign w_jump_target   = {i_pc4_d[31:28], i_instr_index_d, 2'b00};

   always_comb begin
      // NOTE: assign a default before the case so no path leaves o_npc
      // unassigned, which would infer a latch.
      o_npc = w_pc4_f;
      case (npc_sel_e'(i_npc_sel))
         NPC_SEL_BRANCH: if (i_br_cond) o_npc = w_branch_target;
         NPC_SEL_JUMP:   o_npc = w_jump_target;
         NPC_SEL_JREG:   o_npc = i_rs_val_d;   // taken as-is, no alignment forcing
         default:        o_npc = w_pc4_f;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   IF stage of the 5-stage MIPS pipeline. Holds the architectural PC, reads
//   the instruction ROM asynchronously and loads the next PC chosen by the
//   D-stage redirect. Branch/jump resolve in D with one delay slot, so there
//   is no flush here. Outputs feed the IF/ID pipeline register directly.
// Parameters
//   RESET_PC  PC after reset and base byte address of the ROM
//   IM_WORDS  ROM depth in 32-bit words (power of 2)
//   IM_IMAGE  ROM contents, word i at byte address RESET_PC + 4*i
//             (words not supplied read as zero)
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   stall                   hold PC (same signal as the IF/ID stall)
//   npc_sel, br_cond        D-stage redirect request and branch condition
//   PC4_D, imm16_D,
//   instr_index_D, rs_val_D D-stage operands for branch/jump/jr targets
//   instr_F                 instruction at PC_F, nop when pc_fault
//   PC_F, PC4_F, PC8_F      fetch PC and its +4 / +8 link values
//   pc_fault                PC_F misaligned or outside the ROM window
// ----------------------------------------------------------------------------
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0]                 RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned                 IM_WORDS = IM_WORDS_DEFAULT,
   parameter logic [IM_WORDS-1:0][31:0]   IM_IMAGE = '0
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [1:0]  npc_sel,
   input  logic        br_cond,
   input  logic [31:0] PC4_D,
   input  logic [15:0] imm16_D,
   input  logic [25:0] instr_index_D,
   input  logic [31:0] rs_val_D,
   output logic [31:0] instr_F,
   output logic [31:0] PC_F,
   output logic [31:0] PC4_F,
   output logic [31:0] PC8_F,
   output logic        pc_fault
);

   localparam int unsigned ADDR_W   = $clog2(IM_WORDS);
   localparam logic [31:0] IM_BYTES = 32'(IM_WORDS * 4);

   logic [31:0]       r_pc;
   logic [31:0]       w_npc;
   logic [31:0]       w_offset;
   logic [ADDR_W-1:0] w_index;
   logic              w_in_range;
   logic              w_misaligned;

   fetch_unit_npc_calc u_npc_calc (
      .i_npc_sel       (npc_sel),
      .i_br_cond       (br_cond),
      .i_pc_f          (r_pc),
      .i_pc4_d         (PC4_D),
      .i_imm16_d       (imm16_D),
      .i_instr_index_d (instr_index_D),
      .i_rs_val_d      (rs_val_D),
      .o_pc4_f         (PC4_F),
      .o_pc8_f         (PC8_F),
      .o_npc           (w_npc)
   );

   // Priority: reset > stall > next-PC. A stalled D instruction re-presents
   // its request once the stall drops, so ignoring npc_sel here loses nothing.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of block ordering.
      if (reset) begin
         r_pc <= RESET_PC;
      end else if (!stall) begin
         r_pc <= w_npc;
      end
   end

   // Offset from the ROM base; a PC below the base wraps to a huge offset,
   // so a single unsigned compare covers both ends of the window.
   assign w_offset     = r_pc - RESET_PC;
   assign w_in_range   = (w_offset < IM_BYTES);
   assign w_misaligned = (r_pc[1:0] != 2'b00);
   assign w_index      = w_offset[ADDR_W+1:2];

   // The ROM is a constant image, never written and never reset.
   assign pc_fault = w_misaligned || !w_in_range;
   assign instr_F  = pc_fault ? INSTR_NOP : IM_IMAGE[w_index];
   assign PC_F     = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed and randomized stimulus for fetch_unit, checked against a
//   behavioural next-PC model written with plain integer arithmetic.
// ----------------------------------------------------------------------------
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam logic [31:0] RPC   = 32'h0000_3000;
   localparam int          WORDS = 1024;

   typedef logic [WORDS-1:0][31:0] img_t;

   // Distinct, non-zero word per address so a wrong ROM index is visible.
   function automatic img_t gen_img();
      img_t img;
      for (int i = 0; i < WORDS; i++) begin
         img[i] = {16'h2400 | 16'(i), 16'(i * 40503 + 17)};
      end
      return img;
   endfunction

   localparam img_t IMG = gen_img();

   logic        clk;
   logic        reset;
   logic        stall;
   logic [1:0]  npc_sel;
   logic        br_cond;
   logic [31:0] PC4_D;
   logic [15:0] imm16_D;
   logic [25:0] instr_index_D;
   logic [31:0] rs_val_D;
   logic [31:0] instr_F;
   logic [31:0] PC_F;
   logic [31:0] PC4_F;
   logic [31:0] PC8_F;
   logic        pc_fault;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] m_pc;

   fetch_unit #(
      .RESET_PC (RPC),
      .IM_WORDS (WORDS),
      .IM_IMAGE (IMG)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .npc_sel       (npc_sel),
      .br_cond       (br_cond),
      .PC4_D         (PC4_D),
      .imm16_D       (imm16_D),
      .instr_index_D (instr_index_D),
      .rs_val_D      (rs_val_D),
      .instr_F       (instr_F),
      .PC_F          (PC_F),
      .PC4_F         (PC4_F),
      .PC8_F         (PC8_F),
      .pc_fault      (pc_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic drive(input logic r, input logic s, input logic [1:0] sel,
                        input logic br, input logic [31:0] pc4d,
                        input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] rs);
      reset = r; stall = s; npc_sel = sel; br_cond = br;
      PC4_D = pc4d; imm16_D = imm; instr_index_D = idx; rs_val_D = rs;
   endtask

   // Model: evaluate the architectural next-PC rule on the pre-edge inputs,
   // advance one edge, then commit. Arithmetic is done wide and reduced mod 2^32.
   task automatic tick();
      longint nxt;
      if (reset)      nxt = longint'(RPC);
      else if (stall) nxt = longint'(m_pc);
      else begin
         case (int'(npc_sel))
            1:       nxt = br_cond ? longint'(PC4_D) + 4 * longint'($signed(imm16_D))
                                   : longint'(m_pc) + 4;
            2:       nxt = (longint'(PC4_D) / 268435456) * 268435456
                           + 4 * longint'(instr_index_D);
            3:       nxt = longint'(rs_val_D);
            default: nxt = longint'(m_pc) + 4;
         endcase
      end
      @(posedge clk);
      #1;
      m_pc = nxt[31:0];
   endtask

   task automatic check_all(input string tag);
      logic [31:0] e_instr;
      logic        e_fault;
      int          idx;
      e_fault = (m_pc % 4 != 0) || (m_pc < RPC)
                || (longint'(m_pc) >= longint'(RPC) + 4 * WORDS);
      e_instr = 32'h0;
      if (!e_fault) begin
         idx     = int'((m_pc - RPC) / 4);
         e_instr = IMG[idx];
      end
      check({tag, ".pc"},    PC_F,  m_pc);
      check({tag, ".pc4"},   PC4_F, m_pc + 32'd4);
      check({tag, ".pc8"},   PC8_F, m_pc + 32'd8);
      check({tag, ".instr"}, instr_F, e_instr);
      check({tag, ".fault"}, {31'b0, pc_fault}, {31'b0, e_fault});
   endtask

   initial begin
      m_pc = 32'h0;

      // Reset held for two edges.
      drive(1'b1, 1'b0, NPC_SEL_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick(); tick();
      check_all("rst");
      check("rst.pc_lit", PC_F, 32'h3000);
      check("rst.instr0", instr_F, IMG[0]);

      // Sequential fetch.
      drive(1'b0, 1'b0, NPC_SEL_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick(); check_all("seq1"); check("seq1.lit", PC_F, 32'h3004);
      tick(); check_all("seq2"); check("seq2.lit", PC_F, 32'h3008);
      tick(); check_all("seq3"); check("seq3.lit", PC_F, 32'h300C);

      // Stall at 0x3008 with a pending jump, then release.
      drive(1'b1, 1'b0, NPC_SEL_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick();
      drive(1'b0, 1'b0, NPC_SEL_SEQ, 1'b0, 32'h0, 16'h0, 26'h0, 32'h0);
      tick(); tick();
      check("stl.pre", PC_F, 32'h3008);
      drive(1'b0, 1'b1, NPC_SEL_JUMP, 1'b0, 32'h3020, 16'h0, 26'h0000C05, 32'h0);
      tick(); check_all("stl1");
      tick(); check_all("stl2"); check("stl2.lit", PC_F, 32'h3008);
      stall = 1'b0;
      tick(); check_all("stl.rel"); check("stl.rel.lit", PC_F, 32'h3014);

      // Branches.
      drive(1'b0, 1'b0, NPC_SEL_BRANCH, 1'b1, 32'h3010, 16'hFFFC, 26'h0, 32'h0);
      tick(); check_all("br_back"); check("br_back.lit", PC_F, 32'h3000);
      imm16_D = 16'h0003;
      tick(); check_all("br_fwd"); check("br_fwd.lit", PC_F, 32'h301C);
      drive(1'b0, 1'b0, NPC_SEL_JUMP, 1'b0, 32'h3020, 16'h0, 26'h0000C05, 32'h0);
      tick(); check_all("jmp"); check("jmp.lit", PC_F, 32'h3014);
      drive(1'b0, 1'b0, NPC_SEL_BRANCH, 1'b0, 32'h3018, 16'h0010, 26'h0, 32'h0);
      tick(); check_all("br_nt"); check("br_nt.lit", PC_F, 32'h3018);

      // Register jumps, misaligned target and ROM window edges.
      drive(1'b0, 1'b0, NPC_SEL_JREG, 1'b0, 32'h0, 16'h0, 26'h0, 32'h3040);
      tick(); check_all("jr"); check("jr.lit", PC_F, 32'h3040);
      rs_val_D = 32'h3042;
      tick(); check_all("jr_mis");
      check("jr_mis.fault", {31'b0, pc_fault}, 32'd1);
      check("jr_mis.instr", instr_F, 32'h0);
      rs_val_D = 32'h4000;
      tick(); check_all("top_out"); check("top_out.fault", {31'b0, pc_fault}, 32'd1);
      rs_val_D = 32'h3FFC;
      tick(); check_all("top_in"); check("top_in.instr", instr_F, IMG[WORDS-1]);
      rs_val_D = 32'h2FFC;
      tick(); check_all("below");
      rs_val_D = 32'hFFFF_FFFC;
      tick(); check_all("wrap0");
      npc_sel = NPC_SEL_SEQ;
      tick(); check_all("wrap1"); check("wrap1.lit", PC_F, 32'h0);

      // Reset beats stall and a redirect request.
      drive(1'b1, 1'b1, NPC_SEL_JREG, 1'b1, 32'h0, 16'h0, 26'h0, 32'h5000);
      tick(); check_all("rst_pri");
      check("rst_pri.lit", PC_F, 32'h3000);
      check("rst_pri.fault", {31'b0, pc_fault}, 32'd0);

      // Randomized traffic, mostly inside the ROM window.
      for (int n = 0; n < 400; n++) begin
         reset         = ($urandom_range(0, 39) == 0);
         stall         = ($urandom_range(0, 3) == 0);
         npc_sel       = 2'($urandom_range(0, 3));
         br_cond       = 1'($urandom_range(0, 1));
         PC4_D         = ($urandom_range(0, 1) == 1) ? m_pc + 32'd4
                         : RPC + 32'(4 * $urandom_range(0, WORDS - 1));
         imm16_D       = 16'($urandom_range(0, 63)) - 16'd32;
         instr_index_D = 26'h0000C00 + 26'($urandom_range(0, WORDS - 1));
         rs_val_D      = ($urandom_range(0, 7) == 0) ? 32'($urandom)
                         : RPC + 32'(4 * $urandom_range(0, WORDS - 1));
         tick();
         check_all("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
